// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Counter must hold 0..N so the final step count is representable.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addsub_row.sv
// W-bit ripple adder/subtractor: s = x + (sub ? ~y : y) + cin.
module addsub_row #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] s
);

  logic [W-1:0] y_eff;
  logic [W-1:0] c;

  assign y_eff = y ^ {W{sub}};
  assign c[0]  = cin;

  for (genvar i = 0; i < W - 1; i++) begin : g_col
    fa u_fa (
      .a  (x[i]),
      .b  (y_eff[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // The carry out of the sign column is never consumed, so only its sum is formed.
  assign s[W-1] = x[W-1] ^ y_eff[W-1] ^ c[W-1];

endmodule

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_multiplier_nbit.sv
// Radix-2 sequential multiplier, unsigned or two's-complement, one multiplier bit per cycle.
module seq_multiplier_nbit
  import seq_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int CW = cnt_w(N);

  mult_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic           sgn_q, sgn_d;
  logic [2*N-1:0] p_q, p_d;

  logic [N:0] mcand_ext;
  logic [N:0] addend;
  logic [N:0] sum;
  logic       last;
  logic       sub_step;

  assign mcand_ext = {sgn_q & mcand_q[N-1], mcand_q};
  assign addend    = lo_q[0] ? mcand_ext : '0;
  assign last      = (cnt_q == CW'(N - 1));
  // The MSB of a two's-complement multiplier carries negative weight.
  assign sub_step  = sgn_q & last & lo_q[0];

  addsub_row #(.W(N + 1)) u_row (
    .x   (hi_q),
    .y   (addend),
    .sub (sub_step),
    .cin (sub_step),
    .s   (sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          sgn_d   = signed_mode;
          cnt_d   = '0;
          hi_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d  = {sgn_q & sum[N], sum[N:1]};
        lo_d  = {sum[0], lo_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Product is the post-shift {hi[N-1:0], lo}, taken straight from this step.
          p_d     = {sum, lo_q[N-1:1]};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_multiplier_nbit.sv
// Directed + scoreboard bench for seq_multiplier_nbit at N=8 and N=4.
module tb_seq_multiplier_nbit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, sm4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  seq_multiplier_nbit #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  seq_multiplier_nbit #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp8_q[$];
  logic [7:0]  exp4_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input bit sm);
    longint mask, av, bv, pr;
    mask = (longint'(1) << n) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (sm && ((av >> (n - 1)) & 1) != 0) av = av - (longint'(1) << n);
    if (sm && ((bv >> (n - 1)) & 1) != 0) bv = bv - (longint'(1) << n);
    pr = av * bv;
    return 64'(pr & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // All tasks start and end on a falling edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                         input logic [15:0] exp);
    int w = 0;
    while (!ir8 && w < 40) begin @(negedge clk); w++; end
    chk("ready8", ir8, 1'b1);
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    exp8_q.push_back(exp);
    @(negedge clk);
    iv8 = 1'b0;
    chk("busy8", busy8, 1'b1);
  endtask

  task automatic collect8(input string tag);
    int lat = 0;
    while (!ov8 && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    iv8 = 1'b0;
    if (exp8_q.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else chk(tag, p8, exp8_q.pop_front());
    if (or8) begin
      @(negedge clk);
      chk({tag, "_ready_after"}, ir8, 1'b1);
    end
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input bit sm,
                      input logic [7:0] exp);
    int lat = 0;
    int w = 0;
    while (!ir4 && w < 40) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, ir4, 1'b1);
    a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1;
    exp4_q.push_back(exp);
    @(negedge clk);
    iv4 = 1'b0;
    while (!ov4 && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    if (exp4_q.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else chk(tag, p4, exp4_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] m;
    logic [15:0] held;
    logic [7:0]  ra, rb;
    bit          rs;
    bit          saw_ov;

    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; sm4 = 0; or4 = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready8", ir8, 1'b1);
    chk("rst_ov8", ov8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_p8", p8, 16'h0);
    chk("rst_p4", p4, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    accept8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    collect8("u_ff_ff");
    accept8(8'h80, 8'h80, 1'b1, 16'h4000);
    collect8("s_min_sq");
    accept8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    collect8("s_m3_5");
    accept8(8'h00, 8'h5A, 1'b0, 16'h0000);
    collect8("u_zero_a");
    accept8(8'h37, 8'h00, 1'b1, 16'h0000);
    collect8("s_zero_b");
    accept8(8'h7F, 8'h80, 1'b1, 16'hC080);
    collect8("s_max_min");

    // Backpressure: hold DONE for five cycles.
    or8 = 1'b0;
    m = model(8, 32'h12, 32'h34, 1'b0);
    accept8(8'h12, 8'h34, 1'b0, m[15:0]);
    collect8("bp");
    held = m[15:0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ov", ov8, 1'b1);
      chk("bp_ready", ir8, 1'b0);
      chk("bp_p", p8, held);
    end
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ir8, 1'b1);
    chk("bp_release_ov", ov8, 1'b0);
    chk("idle_p_held", p8, held);

    // Interference: second pair offered throughout RUN must be ignored.
    accept8(8'd3, 8'd4, 1'b0, 16'h000C);
    a8 = 8'h7F; b8 = 8'h7F; iv8 = 1'b1;
    collect8("interf");
    chk("interf_not_busy", busy8, 1'b0);
    chk("interf_p", p8, 16'h000C);

    // Reset on the 4th RUN cycle.
    accept8(8'h55, 8'h66, 1'b0, 16'h0);
    void'(exp8_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_p", p8, 16'h0);
    chk("midrst_ov", ov8, 1'b0);
    chk("midrst_ready", ir8, 1'b1);
    chk("midrst_busy", busy8, 1'b0);
    saw_ov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8) saw_ov = 1'b1;
    end
    chk("midrst_no_ov", saw_ov, 1'b0);
    accept8(8'd6, 8'd7, 1'b0, 16'h002A);
    collect8("after_rst");

    // Random pairs; inputs scrambled after acceptance.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m = model(8, 32'(ra), 32'(rb), rs);
      accept8(ra, rb, rs, m[15:0]);
      a8 = ~ra; b8 = ~rb; sm8 = ~rs;
      collect8("rand");
    end

    run4("n4_u_15sq", 4'hF, 4'hF, 1'b0, 8'hE1);
    run4("n4_s_m8x7", 4'h8, 4'h7, 1'b1, 8'hC8);
    run4("n4_zero", 4'h0, 4'h9, 1'b0, 8'h00);
    m = model(4, 32'h5, 32'hB, 1'b1);
    run4("n4_s_5xm5", 4'h5, 4'hB, 1'b1, m[7:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
